// File: rtl/skew_fifo.sv
// skew_fifo: per-lane triangular delay buffer feeding the systolic array.
// Lane i is tapped at stage base+i (skew) or base+LANES-1-i (deskew), so
// lane i has a latency of 1+tap enabled cycles.
// Build option SKEW_FIFO_ZERO_INVALID_EN: when defined, q lanes whose
// vld_out bit is low read as zero. When undefined, q shows the raw stage data.
module skew_fifo #(
  parameter int unsigned LANES    = 4,
  parameter int unsigned BITS     = 8,
  parameter int unsigned MAX_BASE = 3,
  localparam int unsigned BASE_W  = (MAX_BASE > 0) ? $clog2(MAX_BASE + 1) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    flush,
  input  logic                    cfg_load,
  input  logic                    cfg_mode,
  input  logic [BASE_W-1:0]       cfg_base,
  input  logic [LANES*BITS-1:0]   d,
  input  logic [LANES-1:0]        vld_in,
  output logic [LANES*BITS-1:0]   q,
  output logic [LANES-1:0]        vld_out,
  output logic                    busy
);

  localparam int unsigned DEPTH = 1 + MAX_BASE + LANES - 1;
  localparam int unsigned TAP_W = $clog2(DEPTH);

  // Stage 0 is the newest entry; stage DEPTH-1 is the oldest.
  logic [DEPTH-1:0][BITS-1:0] dat [LANES];
  logic [DEPTH-1:0]           val [LANES];
  logic                       mode;
  logic [BASE_W-1:0]          base;
  logic [BASE_W-1:0]          cfg_base_sat;
  logic [TAP_W-1:0]           tap;

  // Tap index for a lane under a given mode and base delay.
  function automatic logic [TAP_W-1:0] tap_of(input int unsigned lane,
                                               input logic m,
                                               input logic [BASE_W-1:0] b);
    int unsigned off;
    off = m ? (LANES - 1 - lane) : lane;
    return TAP_W'(32'(b) + off);
  endfunction

  // Base delays above MAX_BASE saturate when loaded.
  assign cfg_base_sat = (32'(cfg_base) > MAX_BASE) ? BASE_W'(MAX_BASE) : cfg_base;

  // Configuration and stage registers; flush beats cfg_load beats shift.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode <= 1'b0;
      base <= '0;
      for (int unsigned i = 0; i < LANES; i++) begin
        dat[i] <= '0;
        val[i] <= '0;
      end
    end else begin
      if (cfg_load) begin
        mode <= cfg_mode;
        base <= cfg_base_sat;
      end
      if (flush) begin
        for (int unsigned i = 0; i < LANES; i++) begin
          dat[i] <= '0;
          val[i] <= '0;
        end
      end else if (cfg_load) begin
        for (int unsigned i = 0; i < LANES; i++) begin
          val[i] <= '0;
        end
      end else if (en) begin
        for (int unsigned i = 0; i < LANES; i++) begin
          val[i] <= {val[i][DEPTH-2:0], vld_in[i]};
          dat[i] <= {dat[i][DEPTH-2:0], d[i*BITS +: BITS]};
        end
      end
    end
  end

  // Output tap mux and occupancy flag, read straight from the stage registers.
  always_comb begin
    q       = '0;
    vld_out = '0;
    busy    = 1'b0;
    tap     = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      tap        = tap_of(i, mode, base);
      vld_out[i] = val[i][tap];
`ifdef SKEW_FIFO_ZERO_INVALID_EN
      q[i*BITS +: BITS] = val[i][tap] ? dat[i][tap] : '0;
`else
      q[i*BITS +: BITS] = dat[i][tap];
`endif
      busy = busy | (|val[i]);
    end
  end

endmodule

// File: tb/tb_skew_fifo.sv
// tb_skew_fifo: directed scenarios with literal expectations, then random
// traffic checked every cycle against a history-based reference model.
module tb_skew_fifo;

  localparam int LANES    = 4;
  localparam int BITS     = 8;
  localparam int MAX_BASE = 3;
  localparam int BW       = 2;
  localparam int L        = LANES + MAX_BASE;
  localparam int HMAX     = 8192;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  en = 1'b0;
  logic                  flush = 1'b0;
  logic                  cfg_load = 1'b0;
  logic                  cfg_mode = 1'b0;
  logic [BW-1:0]         cfg_base = '0;
  logic [LANES*BITS-1:0] d = '0;
  logic [LANES-1:0]      vld_in = '0;
  logic [LANES*BITS-1:0] q;
  logic [LANES-1:0]      vld_out;
  logic                  busy;

  skew_fifo #(.LANES(LANES), .BITS(BITS), .MAX_BASE(MAX_BASE)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .cfg_load(cfg_load),
    .cfg_mode(cfg_mode), .cfg_base(cfg_base), .d(d), .vld_in(vld_in),
    .q(q), .vld_out(vld_out), .busy(busy)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", nm, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // Reference model: every enabled push is logged by its push number. A lane
  // tapped at t shows push (cnt-1-t). Pushes older than the last flush read as
  // zero data; pushes older than the last flush or cfg_load read as invalid.
  int              cnt = 0;
  int              dep = 0;
  int              vep = 0;
  bit              m_mode = 1'b0;
  int              m_base = 0;
  logic [31:0]     hd [HMAX];
  logic [3:0]      hv [HMAX];

  always @(posedge clk) begin
    if (!rst_n) begin
      cnt = 0; dep = 0; vep = 0; m_mode = 1'b0; m_base = 0;
    end else begin
      if (cfg_load) begin
        m_mode = cfg_mode;
        m_base = (int'(cfg_base) > MAX_BASE) ? MAX_BASE : int'(cfg_base);
      end
      if (flush) begin
        dep = cnt;
        vep = cnt;
      end else if (cfg_load) begin
        vep = cnt;
      end else if (en && cnt < HMAX) begin
        hd[cnt] = d;
        hv[cnt] = vld_in;
        cnt++;
      end
    end
  end

  // Per-cycle compare of all outputs against the model.
  always @(negedge clk) begin
    logic [31:0] eq;
    logic [3:0]  ev;
    logic        eb;
    if (chk_on) begin
      eq = '0; ev = '0; eb = 1'b0;
      for (int i = 0; i < LANES; i++) begin
        int t;
        int idx;
        t   = m_base + (m_mode ? (LANES - 1 - i) : i);
        idx = cnt - 1 - t;
        if (idx >= vep) ev[i] = hv[idx][i];
        if (idx >= dep) eq[i*BITS +: BITS] = hd[idx][i*BITS +: BITS];
`ifdef SKEW_FIFO_ZERO_INVALID_EN
        if (!ev[i]) eq[i*BITS +: BITS] = '0;
`endif
      end
      for (int j = cnt - L; j < cnt; j++)
        if (j >= vep && hv[j] != '0) eb = 1'b1;
      chk("model_q", 64'(q), 64'(eq));
      chk("model_vld_out", 64'(vld_out), 64'(ev));
      chk("model_busy", 64'(busy), 64'(eb));
    end
  end

  logic [3:0] t1v [5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0};
  logic [3:0] t2v [7] = '{4'h0, 4'h0, 4'h8, 4'h4, 4'h2, 4'h1, 4'h0};
  logic [3:0] t3v [6] = '{4'h1, 4'h2, 4'h2, 4'h2, 4'h4, 4'h8};
  logic       t3e [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [3:0] t4v [7] = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h3, 4'h7, 4'hF};

  initial begin
    logic [7:0] bv;
    int         lane;

    // Reset state
    rst_n = 1'b0;
    tick;
    chk_on = 1'b1;
    tick;
    chk("rst_q", 64'(q), 64'h0);
    chk("rst_vld_out", 64'(vld_out), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    rst_n = 1'b1;

    // Skew, base 0: lane i appears after i+1 cycles, one-cycle valid pulses
    en = 1'b1; d = 32'h44332211; vld_in = 4'hF;
    tick;
    d = '0; vld_in = '0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick;
      chk("skew_vld", 64'(vld_out), 64'(t1v[k]));
      if (k < LANES) begin
        bv = 8'(8'h11 * (k + 1));
        chk("skew_q", 64'(q[k*BITS +: BITS]), 64'(bv));
      end
    end

    // Deskew, base 2: latencies 6,5,4,3 for lanes 0..3
    en = 1'b0; cfg_load = 1'b1; cfg_mode = 1'b1; cfg_base = 2'd2;
    tick;
    cfg_load = 1'b0; en = 1'b1; d = 32'h44332211; vld_in = 4'hF;
    tick;
    d = '0; vld_in = '0;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) tick;
      chk("deskew_vld", 64'(vld_out), 64'(t2v[k]));
      if (k >= 2 && k <= 5) begin
        lane = 5 - k;
        bv = 8'(8'h11 * (lane + 1));
        chk("deskew_q", 64'(q[lane*BITS +: BITS]), 64'(bv));
      end
    end

    // Skew, base 0, en pattern 1,0,0,1,1 after the load cycle
    cfg_load = 1'b1; cfg_mode = 1'b0; cfg_base = 2'd0;
    tick;
    cfg_load = 1'b0; en = 1'b1; d = 32'hDDCCBBAA; vld_in = 4'hF;
    tick;
    d = '0; vld_in = '0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        en = t3e[k-1];
        tick;
      end
      chk("stall_vld", 64'(vld_out), 64'(t3v[k]));
      if (k >= 1 && k <= 3) chk("stall_q1_hold", 64'(q[15:8]), 64'h0BB);
      if (k == 5) chk("stall_q3", 64'(q[31:24]), 64'h0DD);
    end

    // Mid-stream reconfiguration. The 2-bit cfg_base port cannot encode 5,
    // so the largest encodable value (3, the ceiling) is loaded instead.
    en = 1'b1; vld_in = 4'hF;
    for (int k = 0; k < 6; k++) begin
      d = {4{8'(8'h10 + k)}};
      tick;
    end
    cfg_load = 1'b1; cfg_mode = 1'b0; cfg_base = 2'd3; d = 32'hEEEEEEEE;
    tick;
    cfg_load = 1'b0;
    chk("cfg_vld_clear", 64'(vld_out), 64'h0);
    chk("cfg_busy_clear", 64'(busy), 64'h0);
    for (int k = 1; k <= 7; k++) begin
      d = {4{8'(8'h50 + k - 1)}};
      tick;
      chk("cfg_vld", 64'(vld_out), 64'(t4v[k-1]));
      if (k == 4) chk("cfg_lane0_lat4", 64'(q[7:0]), 64'h050);
    end

    // Flush together with en
    flush = 1'b1; en = 1'b1; d = 32'h12345678; vld_in = 4'hF;
    tick;
    flush = 1'b0;
    chk("flush_q", 64'(q), 64'h0);
    chk("flush_vld", 64'(vld_out), 64'h0);
    chk("flush_busy", 64'(busy), 64'h0);

    // Mid-stream reset, then invalid all-ones data
    rst_n = 1'b0; en = 1'b0; vld_in = '0;
    tick;
    rst_n = 1'b1;
    chk("rst2_q", 64'(q), 64'h0);
    chk("rst2_busy", 64'(busy), 64'h0);
    en = 1'b1; d = 32'hFFFFFFFF; vld_in = '0;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("inv_vld", 64'(vld_out), 64'h0);
`ifdef SKEW_FIFO_ZERO_INVALID_EN
      chk("inv_q_zero", 64'(q), 64'h0);
`else
      if (k == 0) chk("inv_q0_raw", 64'(q[7:0]), 64'h0FF);
`endif
    end

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst_n    = ($urandom_range(0, 299) != 0);
      en       = ($urandom_range(0, 9) < 7);
      flush    = ($urandom_range(0, 59) == 0);
      cfg_load = ($urandom_range(0, 39) == 0);
      cfg_mode = 1'($urandom_range(0, 1));
      cfg_base = BW'($urandom_range(0, 3));
      d        = $urandom;
      vld_in   = 4'($urandom_range(0, 15));
      tick;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/skew_fifo.md
# skew_fifo

Multi-lane delay buffer that feeds the systolic array. It applies a per-lane triangular skew so that lane i is delayed i cycles more than lane 0 (skew mode), or the mirrored delay so that skewed array outputs are realigned (deskew mode). A runtime-programmable common base delay is added to every lane. Each lane carries a valid bit alongside its data. The block is the generalised successor of the single-lane fixed-depth shift fifo and replaces per-lane fifo instances of different depths in the array wrapper.

## Interface
- LANES, 4, number of independent lanes (≥2)
- BITS, 8, data width per lane
- MAX_BASE, 3, largest programmable base delay (≥0)
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- en  in  1  shift enable; all lanes advance one stage when high
- flush  in  1  clear all stored data and valid bits
- cfg_load  in  1  latch cfg_mode/cfg_base into the active configuration
- cfg_mode  in  1  0 = skew, 1 = deskew
- cfg_base  in  $clog2(MAX_BASE+1)  common base delay
- d  in  LANES*BITS  lane i at bits [i*BITS +: BITS]
- vld_in  in  LANES  per-lane input valid
- q  out  LANES*BITS  delayed lane data, same packing as d
- vld_out  out  LANES  per-lane output valid
- busy  out  1  high while any stored valid bit is set

## Operation
- Each lane is a shift register of L = 1+MAX_BASE+LANES-1 stages holding {valid, data}. Stage 0 loads {vld_in[i], d[i]} on en. Stage k loads stage k-1 on en.
- Active tap for lane i is t_i = base + off_i, where off_i = i in skew mode and LANES-1-i in deskew mode. q[i] = data at stage t_i. vld_out[i] = valid at stage t_i. The output read is a combinational mux from registers.
- Lane i latency is therefore 1+t_i enabled cycles. Cycles with en=0 do not count, and all stages hold.
- cfg_base values above MAX_BASE are clamped to MAX_BASE when loaded.
- cfg_load clears every valid bit in the same cycle that the new mode/base takes effect. Data bits are not cleared. This means that stale samples are never reported valid after a reconfiguration.
- flush clears all data and valid bits to 0.
- Priority: rst_n > flush > cfg_load > en. When flush and cfg_load are both asserted, the flush is applied and the configuration is also latched. When cfg_load and en are both asserted, the valid clear takes effect and the shift for that cycle is discarded.
- busy = OR of all valid bits in all stages, including stages beyond the active tap.

## Timing
- Reset: all stages are 0, mode = 0, base = 0, q = 0, vld_out = 0, busy = 0.
- With en held high and skew mode, base = 0: a sample on lane i at cycle N appears at q[i] in cycle N+1+i.
- After cfg_load in cycle N, the new taps apply to outputs from cycle N+1.
- en=0 for any number of cycles freezes q and vld_out.
- Reset or flush asserted mid-stream drops all in-flight samples. The first post-flush sample follows normal latency.

## Configuration
- SKEW_FIFO_ZERO_INVALID_EN: when defined, q[i] is forced to 0 whenever vld_out[i] is 0. This provides the zero padding that the array requires at skew edges.
- When undefined, q[i] presents the raw stage data regardless of valid. This saves one AND per output bit.

## Test plan
Parameters for all scenarios: LANES=4, BITS=8, MAX_BASE=3.
- Reset, then en=1, skew, base=0. Drive d = {0x44,0x33,0x22,0x11} with vld_in=4'hF for one cycle. Required: lane 0 shows 0x11 at +1, lane 1 shows 0x22 at +2, lane 2 shows 0x33 at +3, lane 3 shows 0x44 at +4. Each vld_out bit pulses for exactly one cycle.
- Deskew, base=2, same stimulus. Required latencies: lane 3 = 3, lane 2 = 4, lane 1 = 5, lane 0 = 6.
- Skew, base=0, one sample in flight, en toggled 1,0,0,1,1. Required: lane 3 output appears after exactly 4 enabled cycles, and q holds during the en=0 cycles.
- Stream with vld_in=4'hF, then assert cfg_load (base=5) mid-stream. Required: vld_out=0 until new samples reach the taps, and base reads back as clamped to 3 (lane 0 latency 4).
- Stream, then assert flush together with en. Required: next cycle q=0, vld_out=0, busy=0.
- With SKEW_FIFO_ZERO_INVALID_EN defined, drive d=0xFF on all lanes with vld_in=0. Required: q=0 throughout. Without the macro, required: q[0]=0xFF after 1 cycle while vld_out[0]=0.
